// File: rtl/apb_arb_pkg.sv
// Shared types and defaults for the APB master arbiter.
//   arb_state_e : arbiter FSM states
//   rr_next     : cyclic index helper used by the round-robin search
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ISSUE    = 2'd1,
    WAIT     = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  // Index reached by stepping 'step' places after 'base' on a ring of 'n'.
  function automatic int unsigned rr_next(input int unsigned base,
                                          input int unsigned step,
                                          input int unsigned n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select.
//   req     : request vector, one bit per requester
//   ptr     : index of the last grantee (lowest priority this round)
//   winner  : first requesting index after ptr, cyclically
//   any_req : at least one request pending
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_req
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  int unsigned idx;
  logic        found;

  assign any_req = |req;

  // Scan starting one past the pointer so the last grantee is checked last.
  always_comb begin
    winner = ID_W'(0);
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = rr_next(32'(ptr), k, NUM_REQ);
      if (!found && req[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one apb_master between NUM_REQ requesters, one transfer at a time.
//   PCLK, PRESETn                 : clock, async active-low reset
//   req/req_addr/req_write/req_wdata : requester side, packed slice i = requester i
//   resp_valid/resp_rdata/resp_err   : one-cycle completion back to the grantee
//   busy, grant_id                : status
//   BADDR/BWRITE/BWDATA/start_transfer : command to apb_master
//   BRDATA, BERR                  : one-cycle result from apb_master
//   PSEL/PENABLE/PREADY           : APB bus taps used to spot completion
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  output logic                             resp_err,
  output logic                             busy,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic [ADDR_WIDTH-1:0]            BADDR,
  output logic                             BWRITE,
  output logic [DATA_WIDTH-1:0]            BWDATA,
  output logic                             start_transfer,
  input  logic [DATA_WIDTH-1:0]            BRDATA,
  input  logic                             BERR,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic                             PREADY
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  arb_state_e      state_q;
  arb_state_e      state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            any_req;
  logic            grant;
  logic            done;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  // Unpack the requester buses into per-index arrays.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign done = PSEL & PENABLE & PREADY;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; RESP re-arbitrates so back-to-back grants lose no cycle.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Payload capture at grant and registered status/strobe outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rr_ptr         <= ID_W'(NUM_REQ - 1);
      grant_id       <= ID_W'(0);
      BADDR          <= '0;
      BWRITE         <= 1'b0;
      BWDATA         <= '0;
      start_transfer <= 1'b0;
      busy           <= 1'b0;
      resp_valid     <= '0;
    end else begin
      if (grant) begin
        rr_ptr   <= winner;
        grant_id <= winner;
        BADDR    <= addr_arr[winner];
        BWRITE   <= req_write[winner];
        BWDATA   <= wdata_arr[winner];
      end
      start_transfer <= (state_d == ISSUE);
      busy           <= (state_d != ARB_IDLE);
      // grant_id cannot change on the WAIT->RESP edge, so it is safe to decode here.
      resp_valid     <= (state_d == RESP) ? (NUM_REQ'(1) << grant_id) : '0;
    end
  end

  // apb_master holds BRDATA/BERR for one cycle only, so pass them straight through.
  assign resp_rdata = (state_q == RESP) ? BRDATA : '0;
  assign resp_err   = (state_q == RESP) && BERR;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter with a behavioural apb_master/slave.
module tb_apb_master_arbiter;

  localparam int unsigned NR   = 4;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned IW   = 2;
  localparam int          NCYC = 3000;
  localparam logic [DW-1:0] RD_KEY = 32'hC3C3_3C3C;

  logic               PCLK;
  logic               PRESETn;
  logic [NR-1:0]      req;
  logic [NR*AW-1:0]   req_addr;
  logic [NR-1:0]      req_write;
  logic [NR*DW-1:0]   req_wdata;
  logic [NR-1:0]      resp_valid;
  logic [DW-1:0]      resp_rdata;
  logic               resp_err;
  logic               busy;
  logic [IW-1:0]      grant_id;
  logic [AW-1:0]      BADDR;
  logic               BWRITE;
  logic [DW-1:0]      BWDATA;
  logic               start_transfer;
  logic [DW-1:0]      BRDATA;
  logic               BERR;
  logic               PSEL;
  logic               PENABLE;
  logic               PREADY;

  int checks = 0;
  int errors = 0;

  apb_master_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .PCLK           (PCLK),
    .PRESETn        (PRESETn),
    .req            (req),
    .req_addr       (req_addr),
    .req_write      (req_write),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .busy           (busy),
    .grant_id       (grant_id),
    .BADDR          (BADDR),
    .BWRITE         (BWRITE),
    .BWDATA         (BWDATA),
    .start_transfer (start_transfer),
    .BRDATA         (BRDATA),
    .BERR           (BERR),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PREADY         (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Behavioural apb_master (IDLE/SETUP/ACCESS) with a configurable slave.
  logic          m_setup, m_access;
  int            ws_cnt;
  int            ws_cfg;
  logic          slv_fixed;
  logic [DW-1:0] slv_rdata;
  logic          slv_err;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;
  logic [AW-1:0] done_addr;
  logic          done_write;
  logic [DW-1:0] done_wdata;

  assign PSEL    = m_setup | m_access;
  assign PENABLE = m_access;
  assign PREADY  = !m_access || (ws_cnt >= ws_cfg);
  assign PRDATA  = slv_fixed ? slv_rdata : (BADDR ^ RD_KEY);
  assign PSLVERR = slv_fixed ? slv_err : BADDR[2];

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_setup    <= 1'b0;
      m_access   <= 1'b0;
      ws_cnt     <= 0;
      BRDATA     <= '0;
      BERR       <= 1'b0;
      done_addr  <= '0;
      done_write <= 1'b0;
      done_wdata <= '0;
    end else begin
      BRDATA <= '0;
      BERR   <= 1'b0;
      if (m_access) begin
        if (PREADY) begin
          m_access   <= 1'b0;
          BRDATA     <= PRDATA;
          BERR       <= PSLVERR;
          done_addr  <= BADDR;
          done_write <= BWRITE;
          done_wdata <= BWDATA;
        end else begin
          ws_cnt <= ws_cnt + 1;
        end
      end else if (m_setup) begin
        m_setup  <= 1'b0;
        m_access <= 1'b1;
        ws_cnt   <= 0;
      end else if (start_transfer) begin
        m_setup <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    return NR'(1) << i;
  endfunction

  // Reference rule: first requester after the last grantee, wrapping around.
  function automatic int rr_pick(input logic [NR-1:0] v, input int from);
    for (int k = 1; k <= NR; k++) begin
      if (v[(from + k) % NR]) return (from + k) % NR;
    end
    return from;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_start"}, start_transfer, 0);
    chk({tag, "_valid"}, resp_valid, 0);
    chk({tag, "_rdata"}, resp_rdata, 0);
    chk({tag, "_err"},   resp_err, 0);
    chk({tag, "_gid"},   grant_id, 0);
    chk({tag, "_baddr"}, BADDR, 0);
    chk({tag, "_bwr"},   BWRITE, 0);
    chk({tag, "_bwd"},   BWDATA, 0);
  endtask

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            ws;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vt [4];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int            ord [4];
    int            n_g, n_r, last_resp_cyc;
    int            last, g_id, resp_at;
    bit            outst, free_prev, exp_start, is_resp;
    logic [NR-1:0]    rq_prev;
    logic [NR*AW-1:0] ad_prev;
    logic [NR-1:0]    wr_prev;
    logic [NR*DW-1:0] wd_prev;
    logic [AW-1:0]    g_addr;
    logic             g_wr;
    logic [DW-1:0]    g_wdata;

    vt[0] = '{0, 32'h0000_0010, 1'b0, 32'h0,         32'hA5A5_0001, 1'b0, 0, 4, 32'hA5A5_0001, 1'b0};
    vt[1] = '{2, 32'h0000_0020, 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3, 7, 32'h0000_0000, 1'b0};
    vt[2] = '{1, 32'h0000_0030, 1'b0, 32'h0,         32'h1234_5678, 1'b1, 0, 4, 32'h1234_5678, 1'b1};
    vt[3] = '{3, 32'h0000_0044, 1'b0, 32'h0,         32'hFFFF_0000, 1'b0, 1, 5, 32'hFFFF_0000, 1'b0};

    PRESETn   = 1'b0;
    req       = '0;
    req_addr  = '0;
    req_write = '0;
    req_wdata = '0;
    ws_cfg    = 0;
    slv_fixed = 1'b1;
    slv_rdata = '0;
    slv_err   = 1'b0;
    tick();
    tick();
    chk_reset_vals("por");
    PRESETn = 1'b1;
    tick();

    // Single transfers from idle: latency, capture and stability of payload.
    for (int v = 0; v < 4; v++) begin
      slv_rdata = vt[v].rdata;
      slv_err   = vt[v].err;
      ws_cfg    = vt[v].ws;
      req_addr[vt[v].id*AW +: AW]  = vt[v].addr;
      req_wdata[vt[v].id*DW +: DW] = vt[v].wdata;
      req_write[vt[v].id] = vt[v].wr;
      req[vt[v].id] = 1'b1;
      for (int k = 1; k <= vt[v].exp_lat; k++) begin
        tick();
        chk("tbl_start", start_transfer, k == 1);
        chk("tbl_valid", resp_valid, (k == vt[v].exp_lat) ? onehot(vt[v].id) : '0);
        chk("tbl_busy",  busy, 1);
        chk("tbl_baddr", BADDR, vt[v].addr);
        chk("tbl_bwr",   BWRITE, vt[v].wr);
        chk("tbl_bwd",   BWDATA, vt[v].wdata);
        if (k == 1) begin
          chk("tbl_gid", grant_id, vt[v].id);
          req_addr[vt[v].id*AW +: AW]  = ~vt[v].addr;
          req_wdata[vt[v].id*DW +: DW] = ~vt[v].wdata;
          req_write[vt[v].id] = ~vt[v].wr;
        end
        if (k == vt[v].exp_lat) begin
          chk("tbl_rdata", resp_rdata, vt[v].exp_rdata);
          chk("tbl_err",   resp_err, vt[v].exp_err);
          req[vt[v].id] = 1'b0;
        end else begin
          chk("tbl_rdata_idle", resp_rdata, 0);
          chk("tbl_err_idle",   resp_err, 0);
        end
      end
      tick();
      chk("tbl_post_valid", resp_valid, 0);
      chk("tbl_post_busy",  busy, 0);
      chk("tbl_post_start", start_transfer, 0);
    end

    // Contention 0,1,3 after last grantee 3; 0 re-requests; error on requester 1.
    ord = '{0, 1, 3, 0};
    slv_rdata = 32'h0BAD_F00D;
    ws_cfg = 0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = AW'(32'h100 + i * 4);
      req_write[i] = 1'b0;
    end
    req = 4'b1011;
    n_g = 0;
    n_r = 0;
    last_resp_cyc = -1;
    for (int cyc = 0; cyc < 60 && n_r < 4; cyc++) begin
      tick();
      if (start_transfer && n_g < 4) begin
        chk("arb_order", grant_id, ord[n_g]);
        chk("arb_b2b", cyc, last_resp_cyc + 1);
        slv_err = (ord[n_g] == 1);
        if (ord[n_g] == 3) req[0] = 1'b1;
        n_g++;
      end
      if (resp_valid != '0 && n_r < 4) begin
        chk("arb_resp", resp_valid, onehot(ord[n_r]));
        chk("arb_err",  resp_err, ord[n_r] == 1);
        req[ord[n_r]] = 1'b0;
        last_resp_cyc = cyc;
        n_r++;
      end
    end
    chk("arb_count", n_r, 4);
    slv_err = 1'b0;
    tick();
    tick();
    chk("arb_idle", busy, 0);

    // Reset during ACCESS drops the transfer; scan restarts at requester 0.
    ws_cfg = 5;
    req_addr[2*AW +: AW] = 32'h200;
    req[2] = 1'b1;
    tick();
    chk("rw_start", start_transfer, 1);
    chk("rw_gid", grant_id, 2);
    tick();
    tick();
    #2;
    PRESETn = 1'b0;
    #1;
    chk_reset_vals("rw_async");
    req_addr[1*AW +: AW] = 32'h300;
    req = 4'b0110;
    tick();
    chk("rw_noresp0", resp_valid, 0);
    tick();
    chk("rw_noresp1", resp_valid, 0);
    #3;
    PRESETn = 1'b1;
    ws_cfg = 0;
    tick();
    chk("rw_restart", start_transfer, 1);
    chk("rw_regid", grant_id, 1);
    req[2] = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("rw_valid", resp_valid, (k == 4) ? onehot(1) : '0);
    end
    req = '0;
    tick();
    tick();

    // Randomised traffic against the transaction-level model.
    #2;
    PRESETn = 1'b0;
    tick();
    chk_reset_vals("rnd_rst");
    PRESETn = 1'b1;
    slv_fixed = 1'b0;
    last = NR - 1;
    outst = 1'b0;
    free_prev = 1'b1;
    g_id = 0;
    resp_at = 0;
    g_addr = '0;
    g_wr = 1'b0;
    g_wdata = '0;
    rq_prev = req;
    ad_prev = req_addr;
    wr_prev = req_write;
    wd_prev = req_wdata;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      tick();
      exp_start = free_prev && (rq_prev != '0);
      chk("rnd_start", start_transfer, exp_start);
      if (exp_start) begin
        g_id    = rr_pick(rq_prev, last);
        last    = g_id;
        g_addr  = ad_prev[g_id*AW +: AW];
        g_wr    = wr_prev[g_id];
        g_wdata = wd_prev[g_id*DW +: DW];
        chk("rnd_gid",   grant_id, g_id);
        chk("rnd_baddr", BADDR, g_addr);
        chk("rnd_bwr",   BWRITE, g_wr);
        chk("rnd_bwd",   BWDATA, g_wdata);
        outst   = 1'b1;
        ws_cfg  = int'($urandom_range(0, 3));
        resp_at = cyc + 3 + ws_cfg;
      end
      is_resp = outst && (cyc == resp_at);
      chk("rnd_busy",  busy, outst);
      chk("rnd_valid", resp_valid, is_resp ? onehot(g_id) : '0);
      chk("rnd_rdata", resp_rdata, is_resp ? (g_addr ^ RD_KEY) : '0);
      chk("rnd_err",   resp_err, is_resp ? g_addr[2] : 1'b0);
      if (is_resp) begin
        chk("rnd_bus_addr", done_addr, g_addr);
        chk("rnd_bus_wr",   done_write, g_wr);
        chk("rnd_bus_wd",   done_wdata, g_wdata);
        outst = 1'b0;
        req[g_id] = 1'b0;
      end
      free_prev = !outst;
      if (exp_start && req[g_id]) begin
        if ($urandom_range(0, 9) == 0) begin
          req[g_id] = 1'b0;
        end else begin
          req_addr[g_id*AW +: AW]  = $urandom;
          req_wdata[g_id*DW +: DW] = $urandom;
          req_write[g_id] = ~req_write[g_id];
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (!req[i] && !(outst && i == g_id) && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_addr[i*AW +: AW]  = $urandom;
          req_wdata[i*DW +: DW] = $urandom;
          req_write[i] = 1'($urandom_range(0, 1));
        end
      end
      rq_prev = req;
      ad_prev = req_addr;
      wr_prev = req_write;
      wd_prev = req_wdata;
    end
    req = '0;
    for (int k = 0; k < 12; k++) tick();
    chk("rnd_drain", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
